// File: rtl/column_multiplier_mlane.sv
// -----------------------------------------------------------------------------
// column_multiplier_mlane
//   Element-wise float32 vector multiplier built from LANES handshaked
//   single_multiplier instances. It processes ceil(SIZE/LANES) batches of
//   elements. It supports a broadcast mode that multiplies every a[i] by b[0].
//
//   Ports (top):
//     in_clk     : clock, rising edge
//     in_reset   : asynchronous active-low reset
//     in_a, in_b : packed operand vectors, element i at [i*CELL_WIDTH +: CELL_WIDTH]
//     in_mode    : 0 = a[i]*b[i], 1 = a[i]*b[0]
//     in_ready   : job request, sampled in IDLE only
//     out_ack    : result consumed, sampled in DONE only
//     out_ready  : result valid (DONE)
//     out_busy   : job in progress (ISSUE or COLLECT)
//     out_batch  : index of the batch being processed
//     out_c      : packed result vector
//
//   single_multiplier ports:
//     clk, rst (synchronous, active-high), input_a/_stb/_ack,
//     input_b/_stb/_ack, output_z/_stb/_ack
// -----------------------------------------------------------------------------

// IEEE-754 single-precision multiplier with a stb/ack handshake on each port.
// Subnormal operands are treated as zero and underflowing results flush to
// zero. Rounding is round-to-nearest-even.
module single_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    typedef enum logic [1:0] {M_GET_A, M_GET_B, M_CALC, M_PUT} mstate_e;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    mstate_e     state_q;
    logic [31:0] a_q, b_q, z_q;

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        sign;
        logic [7:0]  ea, eb;
        logic [47:0] prod;
        logic [22:0] mant;
        logic        guard, sticky;
        logic [23:0] rounded;
        int          e;
        sign = a[31] ^ b[31];
        ea   = a[30:23];
        eb   = b[30:23];
        if ((ea == 8'hFF && a[22:0] != 23'd0) || (eb == 8'hFF && b[22:0] != 23'd0))
            return QNAN;
        if (ea == 8'hFF || eb == 8'hFF) begin
            if (ea == 8'd0 || eb == 8'd0)
                return QNAN;                         // inf * 0
            return {sign, 8'hFF, 23'd0};
        end
        if (ea == 8'd0 || eb == 8'd0)
            return {sign, 31'd0};
        prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e    = int'(ea) + int'(eb) - 127;
        // The product of two 1.x mantissas lies in [1,4); renormalise on bit 47.
        if (prod[47]) begin
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            e      = e + 1;
        end else begin
            mant   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        rounded = {1'b0, mant} + 24'(guard && (sticky || mant[0]));
        if (rounded[23])
            e = e + 1;                               // mantissa rolled over to 1.0
        if (e >= 255)
            return {sign, 8'hFF, 23'd0};
        if (e <= 0)
            return {sign, 31'd0};
        return {sign, e[7:0], rounded[22:0]};
    endfunction

    // NOTE: operand and result registers hold pure datapath values that are
    // only read after being loaded, so they sit in a reset-free block.
    always_ff @(posedge clk) begin
        if (state_q == M_GET_A && input_a_ack && input_a_stb) a_q <= input_a;
        if (state_q == M_GET_B && input_b_ack && input_b_stb) b_q <= input_b;
        if (state_q == M_CALC) z_q <= fp_mul(a_q, b_q);
    end

    // NOTE: every sequential assignment is non-blocking so all registers update
    // from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= M_GET_A;
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z_stb <= 1'b0;
        end else begin
            case (state_q)
                M_GET_A: begin
                    input_a_ack <= 1'b1;
                    if (input_a_ack && input_a_stb) begin
                        input_a_ack <= 1'b0;
                        state_q     <= M_GET_B;
                    end
                end
                M_GET_B: begin
                    input_b_ack <= 1'b1;
                    if (input_b_ack && input_b_stb) begin
                        input_b_ack <= 1'b0;
                        state_q     <= M_CALC;
                    end
                end
                M_CALC: state_q <= M_PUT;
                M_PUT: begin
                    output_z_stb <= 1'b1;
                    if (output_z_stb && output_z_ack) begin
                        output_z_stb <= 1'b0;
                        state_q      <= M_GET_A;
                    end
                end
                default: state_q <= M_GET_A;
            endcase
        end
    end

    assign output_z = z_q;
endmodule

module column_multiplier_mlane #(
    parameter  int SIZE       = 4,
    parameter  int LANES      = 2,
    parameter  int CELL_WIDTH = 32,
    localparam int WIDTH      = CELL_WIDTH * SIZE,
    localparam int NBATCH     = (SIZE + LANES - 1) / LANES,
    localparam int BW         = $clog2(NBATCH) + 1
) (
    input  logic             in_clk,
    input  logic             in_reset,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    input  logic             in_ready,
    input  logic             out_ack,
    output logic             out_ready,
    output logic             out_busy,
    output logic [BW-1:0]    out_batch,
    output logic [WIDTH-1:0] out_c
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_COLLECT = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e                state_q;
    logic [WIDTH-1:0]      a_q, b_q;
    logic                  mode_q;
    logic [WIDTH-1:0]      out_c_q, out_c_d;
    logic                  out_ready_q, busy_q;
    logic [BW-1:0]         batch_q;
    logic [LANES-1:0]      a_seen_q, a_seen_d, b_seen_q, b_seen_d, done_q, done_d;
    logic [LANES-1:0]      lane_active;
    logic [LANES-1:0]      lane_a_stb, lane_a_ack, lane_b_stb, lane_b_ack;
    logic [LANES-1:0]      lane_z_stb, lane_z_ack;
    logic [CELL_WIDTH-1:0] lane_a [LANES];
    logic [CELL_WIDTH-1:0] lane_b [LANES];
    logic [CELL_WIDTH-1:0] lane_z [LANES];
    logic                  all_issued, all_done, last_batch, mult_rst;
    int                    elem;

    // Multipliers are held in reset while idle, so a new job always starts
    // them from a clean state (including after an aborted job).
    assign mult_rst   = (state_q == S_IDLE);
    assign last_batch = (batch_q == BW'(NBATCH - 1));

    // Operands are only consumed after a job has been accepted.
    always_ff @(posedge in_clk) begin
        if (state_q == S_IDLE && in_ready) begin
            a_q    <= in_a;
            b_q    <= in_b;
            mode_q <= in_mode;
        end
    end

    // Per-lane routing, handshakes and result capture for the current batch.
    always_comb begin
        // NOTE: every signal gets a default before any conditional assignment,
        // otherwise paths that skip an assignment would infer latches.
        elem       = 0;
        out_c_d    = out_c_q;
        a_seen_d   = a_seen_q;
        b_seen_d   = b_seen_q;
        done_d     = done_q;
        all_issued = 1'b1;
        all_done   = 1'b1;
        for (int j = 0; j < LANES; j++) begin
            elem           = int'(batch_q) * LANES + j;
            lane_active[j] = (elem < SIZE);
            lane_a[j]      = '0;
            lane_b[j]      = '0;
            if (lane_active[j]) begin
                lane_a[j] = a_q[elem*CELL_WIDTH +: CELL_WIDTH];
                lane_b[j] = mode_q ? b_q[CELL_WIDTH-1:0] : b_q[elem*CELL_WIDTH +: CELL_WIDTH];
            end
            // Strobes stay up until the matching ack has been observed.
            lane_a_stb[j] = (state_q == S_ISSUE) && lane_active[j] && !a_seen_q[j];
            lane_b_stb[j] = (state_q == S_ISSUE) && lane_active[j] && !b_seen_q[j];
            a_seen_d[j]   = a_seen_q[j] | (lane_a_stb[j] & lane_a_ack[j]);
            b_seen_d[j]   = b_seen_q[j] | (lane_b_stb[j] & lane_b_ack[j]);
            // The done flag masks the ack, so each lane acks exactly once per batch.
            lane_z_ack[j] = (state_q == S_COLLECT) && lane_active[j] && !done_q[j]
                            && lane_z_stb[j];
            done_d[j]     = done_q[j] | lane_z_ack[j];
            if (lane_z_ack[j])
                out_c_d[elem*CELL_WIDTH +: CELL_WIDTH] = lane_z[j];
            if (lane_active[j] && !(a_seen_d[j] && b_seen_d[j]))
                all_issued = 1'b0;
            if (lane_active[j] && !done_d[j])
                all_done = 1'b0;
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        single_multiplier u_mul (
            .clk          (in_clk),
            .rst          (mult_rst),
            .input_a      (lane_a[j]),
            .input_a_stb  (lane_a_stb[j]),
            .input_a_ack  (lane_a_ack[j]),
            .input_b      (lane_b[j]),
            .input_b_stb  (lane_b_stb[j]),
            .input_b_ack  (lane_b_ack[j]),
            .output_z     (lane_z[j]),
            .output_z_stb (lane_z_stb[j]),
            .output_z_ack (lane_z_ack[j])
        );
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q     <= S_IDLE;
            out_c_q     <= '0;
            out_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            batch_q     <= '0;
            a_seen_q    <= '0;
            b_seen_q    <= '0;
            done_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    out_ready_q <= 1'b0;
                    if (in_ready) begin
                        out_c_q  <= '0;
                        batch_q  <= '0;
                        a_seen_q <= '0;
                        b_seen_q <= '0;
                        done_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    a_seen_q <= a_seen_d;
                    b_seen_q <= b_seen_d;
                    if (all_issued)
                        state_q <= S_COLLECT;
                end
                S_COLLECT: begin
                    out_c_q <= out_c_d;
                    done_q  <= done_d;
                    if (all_done) begin
                        done_q   <= '0;
                        a_seen_q <= '0;
                        b_seen_q <= '0;
                        batch_q  <= batch_q + BW'(1);
                        if (last_batch) begin
                            state_q     <= S_DONE;
                            out_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ack) begin
                        state_q     <= S_IDLE;
                        out_ready_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_ready = out_ready_q;
    assign out_busy  = busy_q;
    assign out_batch = batch_q;
    assign out_c     = out_c_q;
endmodule

// File: tb/tb_column_multiplier_mlane.sv
module tb_column_multiplier_mlane;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [159:0] in_a_w = '0;
    logic [159:0] in_b_w = '0;
    logic         in_mode = 1'b0;
    logic         out_ack = 1'b0;
    logic [2:0]   req = '0;

    logic [127:0] c0, c2;
    logic [159:0] c1;
    logic         rdy0, rdy1, rdy2, busy0, busy1, busy2;
    logic [1:0]   bat0;
    logic [2:0]   bat1;
    logic [0:0]   bat2;

    int checks = 0;
    int errors = 0;
    logic [159:0] sb_q[$];

    always #5 clk = ~clk;

    // dut0: SIZE=4 LANES=2, dut1: SIZE=5 LANES=2, dut2: SIZE=LANES=4
    column_multiplier_mlane #(.SIZE(4), .LANES(2)) dut0 (
        .in_clk(clk), .in_reset(rst_n), .in_a(in_a_w[127:0]), .in_b(in_b_w[127:0]),
        .in_mode(in_mode), .in_ready(req[0]), .out_ack(out_ack), .out_ready(rdy0),
        .out_busy(busy0), .out_batch(bat0), .out_c(c0));
    column_multiplier_mlane #(.SIZE(5), .LANES(2)) dut1 (
        .in_clk(clk), .in_reset(rst_n), .in_a(in_a_w), .in_b(in_b_w),
        .in_mode(in_mode), .in_ready(req[1]), .out_ack(out_ack), .out_ready(rdy1),
        .out_busy(busy1), .out_batch(bat1), .out_c(c1));
    column_multiplier_mlane #(.SIZE(4), .LANES(4)) dut2 (
        .in_clk(clk), .in_reset(rst_n), .in_a(in_a_w[127:0]), .in_b(in_b_w[127:0]),
        .in_mode(in_mode), .in_ready(req[2]), .out_ack(out_ack), .out_ready(rdy2),
        .out_busy(busy2), .out_batch(bat2), .out_c(c2));

    // ---------------- lane monitors ----------------
    logic mon1_en = 1'b0;
    int   lane1_bad, lane0_b2;
    always @(negedge clk) begin
        if (!mon1_en) begin
            lane1_bad <= 0;
            lane0_b2  <= 0;
        end else if (busy1 && bat1 == 3'd2) begin
            if (dut1.lane_a_stb[1] || dut1.lane_b_stb[1]) lane1_bad <= lane1_bad + 1;
            if (dut1.lane_a_stb[0]) lane0_b2 <= lane0_b2 + 1;
        end
    end

    logic mon2_en = 1'b0;
    int   cyc2, cap_cycles, cap_cyc, ready_cyc;
    int   ack_cnt [4];
    always @(negedge clk) begin
        if (!mon2_en) begin
            cyc2       <= 0;
            cap_cycles <= 0;
            cap_cyc    <= -1;
            ready_cyc  <= -1;
            for (int j = 0; j < 4; j++) ack_cnt[j] <= 0;
        end else begin
            cyc2 <= cyc2 + 1;
            if (|dut2.lane_z_ack) begin
                cap_cycles <= cap_cycles + 1;
                cap_cyc    <= cyc2;
            end
            for (int j = 0; j < 4; j++)
                if (dut2.lane_z_ack[j]) ack_cnt[j] <= ack_cnt[j] + 1;
            if (rdy2 && ready_cyc < 0) ready_cyc <= cyc2;
        end
    end

    // ---------------- model and helpers ----------------
    // Float32 product via exact double multiplication, then round-to-nearest-even
    // back to single. Valid for normal operands with a normal result.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] da, db, dp;
        logic [22:0] keep;
        logic [30:0] mag;
        da   = {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0};
        db   = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        dp   = $realtobits($bitstoreal(da) * $bitstoreal(db));
        keep = dp[51:29];
        mag  = {8'(dp[62:52] - 11'd896), keep};
        if (dp[28] && ((|dp[27:0]) || keep[0])) mag = mag + 31'd1;
        return {dp[63], mag};
    endfunction

    function automatic logic [31:0] rand_f();
        return {1'($urandom_range(0, 1)), 8'(100 + $urandom_range(0, 54)), 23'($urandom)};
    endfunction

    function automatic logic [159:0] rand_vec();
        logic [159:0] v;
        for (int i = 0; i < 5; i++) v[i*32 +: 32] = rand_f();
        return v;
    endfunction

    function automatic logic [159:0] model_vec(input logic [159:0] a, input logic [159:0] b,
                                               input logic mode, input int size);
        logic [159:0] r = '0;
        for (int i = 0; i < size; i++)
            r[i*32 +: 32] = fp_model(a[i*32 +: 32], mode ? b[31:0] : b[i*32 +: 32]);
        return r;
    endfunction

    function automatic int size_of(input int w);
        return (w == 1) ? 5 : 4;
    endfunction

    function automatic int nbatch_of(input int w);
        return (w == 0) ? 2 : (w == 1) ? 3 : 1;
    endfunction

    function automatic logic get_rdy(input int w);
        return (w == 0) ? rdy0 : (w == 1) ? rdy1 : rdy2;
    endfunction

    function automatic logic [159:0] get_c(input int w);
        return (w == 0) ? {32'd0, c0} : (w == 1) ? c1 : {32'd0, c2};
    endfunction

    function automatic int get_batch(input int w);
        return (w == 0) ? int'(bat0) : (w == 1) ? int'(bat1) : int'(bat2);
    endfunction

    task automatic start_job(input int w, input logic [159:0] a, input logic [159:0] b,
                             input logic mode, input logic [159:0] expv);
        @(negedge clk);
        in_a_w  = a;
        in_b_w  = b;
        in_mode = mode;
        req[w]  = 1'b1;
        sb_q.push_back(expv);
        @(negedge clk);
        req[w] = 1'b0;
    endtask

    // Waits (bounded) for out_ready, pops the scoreboard and compares the result.
    task automatic score_job(input int w, input string name, input logic do_ack);
        int           n = 0;
        logic [159:0] expv, got;
        while (!get_rdy(w) && n < 300) begin
            @(negedge clk);
            n++;
        end
        expv = sb_q.pop_front();
        checks++;
        if (get_rdy(w) !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: out_ready=%b after %0d cycles, required 1", name, get_rdy(w), n);
            return;
        end
        got = get_c(w);
        for (int i = 0; i < size_of(w); i++) begin
            checks++;
            if (got[i*32 +: 32] !== expv[i*32 +: 32]) begin
                errors++;
                $display("FAIL %s_c[%0d]: got %h, required %h", name, i, got[i*32 +: 32], expv[i*32 +: 32]);
            end
        end
        checks++;
        if (get_batch(w) !== nbatch_of(w)) begin
            errors++;
            $display("FAIL %s_batch: got %0d, required %0d", name, get_batch(w), nbatch_of(w));
        end
        if (do_ack) begin
            out_ack = 1'b1;
            @(negedge clk);
            out_ack = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #12;
        checks++;
        if ({c0, c1, c2} !== '0) begin
            errors++;
            $display("FAIL reset_c: got %h %h %h, required 0", c0, c1, c2);
        end
        checks++;
        if ({rdy0, rdy1, rdy2, busy0, busy1, busy2} !== 6'd0) begin
            errors++;
            $display("FAIL reset_flags: ready=%b%b%b busy=%b%b%b, required 0", rdy0, rdy1, rdy2, busy0, busy1, busy2);
        end
        checks++;
        if ({bat0, bat1, bat2} !== 6'd0) begin
            errors++;
            $display("FAIL reset_batch: got %0d %0d %0d, required 0", bat0, bat1, bat2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_elementwise();
        start_job(0, {32'd0, 32'h3F000000, 32'h40400000, 32'h40000000, 32'h3F800000},
                     {32'd0, 32'hC0000000, 32'h40000000, 32'h40400000, 32'h40000000}, 1'b0,
                     {32'd0, 32'hBF800000, 32'h40C00000, 32'h40C00000, 32'h40000000});
        score_job(0, "elementwise", 1'b1);
    endtask

    task automatic test_broadcast();
        start_job(0, {32'd0, 32'h3F000000, 32'h40400000, 32'h40000000, 32'h3F800000},
                     {32'd0, 32'h12345678, 32'hC1200000, 32'h7F7FFFFF, 32'h40000000}, 1'b1,
                     {32'd0, 32'h3F800000, 32'h40C00000, 32'h40800000, 32'h40000000});
        score_job(0, "broadcast", 1'b1);
    endtask

    task automatic test_partial_batch();
        logic [159:0] a, b;
        for (int m = 0; m < 2; m++) begin
            a = rand_vec();
            b = rand_vec();
            mon1_en = 1'b1;
            start_job(1, a, b, 1'(m), model_vec(a, b, 1'(m), 5));
            score_job(1, (m == 0) ? "partial_elem" : "partial_bcast", 1'b1);
            checks++;
            if (lane1_bad !== 0 || lane0_b2 == 0) begin
                errors++;
                $display("FAIL partial_lane_stb: lane1 strobe cycles %0d (required 0), lane0 strobe cycles %0d (required >0)", lane1_bad, lane0_b2);
            end
            mon1_en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_all_lanes();
        logic [159:0] a, b;
        a = rand_vec();
        b = rand_vec();
        mon2_en = 1'b1;
        start_job(2, a, b, 1'b0, model_vec(a, b, 1'b0, 4));
        score_job(2, "all_lanes", 1'b1);
        checks++;
        if (cap_cycles !== 1) begin
            errors++;
            $display("FAIL all_lanes_capture_cycles: got %0d, required 1", cap_cycles);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (ack_cnt[j] !== 1) begin
                errors++;
                $display("FAIL all_lanes_zack[%0d]: got %0d pulses, required 1", j, ack_cnt[j]);
            end
        end
        checks++;
        if (ready_cyc !== cap_cyc + 1) begin
            errors++;
            $display("FAIL all_lanes_done_edge: ready at %0d, required %0d", ready_cyc, cap_cyc + 1);
        end
        mon2_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_done_hold();
        logic [159:0] a, b;
        logic [127:0] saved;
        a = rand_vec();
        b = rand_vec();
        start_job(0, a, b, 1'b0, model_vec(a, b, 1'b0, 4));
        score_job(0, "done_hold", 1'b0);
        saved = c0;
        for (int i = 0; i < 10; i++) begin
            req[0] = ~req[0];
            in_a_w = rand_vec();
            in_mode = ~in_mode;
            @(negedge clk);
            checks++;
            if (c0 !== saved || rdy0 !== 1'b1 || busy0 !== 1'b0) begin
                errors++;
                $display("FAIL done_hold_cycle%0d: c=%h ready=%b busy=%b, required c=%h ready=1 busy=0", i, c0, rdy0, busy0, saved);
            end
        end
        req[0]  = 1'b0;
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        checks++;
        if (rdy0 !== 1'b0 || c0 !== saved) begin
            errors++;
            $display("FAIL done_release: ready=%b c=%h, required ready=0 c=%h", rdy0, c0, saved);
        end
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || c0 !== saved) begin
            errors++;
            $display("FAIL idle_hold: busy=%b c=%h, required busy=0 c=%h", busy0, c0, saved);
        end
    endtask

    task automatic test_reset_mid();
        logic [159:0] a, b;
        logic [127:0] pre_c;
        int n = 0;
        a = rand_vec();
        b = rand_vec();
        start_job(0, a, b, 1'b0, '0);
        while (!(dut0.state_q == 2'd2 && bat0 == 2'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(dut0.state_q == 2'd2 && bat0 == 2'd1)) begin
            errors++;
            $display("FAIL reset_mid_reach: state=%0d batch=%0d, required COLLECT batch 1", dut0.state_q, bat0);
        end
        pre_c = c0;
        checks++;
        if (pre_c[63:0] == 64'd0) begin
            errors++;
            $display("FAIL reset_mid_precond: c[1:0]=%h, required nonzero", pre_c[63:0]);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (c0 !== '0 || rdy0 !== 1'b0 || busy0 !== 1'b0 || bat0 !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_async: c=%h ready=%b busy=%b batch=%0d, required all 0", c0, rdy0, busy0, bat0);
        end
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a = rand_vec();
        b = rand_vec();
        start_job(0, a, b, 1'b1, model_vec(a, b, 1'b1, 4));
        score_job(0, "after_reset", 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [159:0] a, b;
        logic         m;
        for (int k = 0; k < 4; k++) begin
            a = rand_vec();
            b = rand_vec();
            m = 1'($urandom_range(0, 1));
            start_job(0, a, b, m, model_vec(a, b, m, 4));
            score_job(0, "back_to_back", 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_elementwise();
        test_broadcast();
        test_partial_batch();
        test_all_lanes();
        test_done_hold();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
